// File: rtl/debounce_sync_ctrl_if.sv
// Button-controller bus: raw pins and enable in, debounced levels, edge pulses and tick out.
// The controller is the slave; whoever drives the pins and enable is the master.
interface debounce_sync_ctrl_if #(
   parameter int N_CH = 4
) ();
   logic            en;
   logic [N_CH-1:0] btn_raw;
   logic [N_CH-1:0] btn_db;
   logic [N_CH-1:0] btn_rise;
   logic [N_CH-1:0] btn_fall;
   logic            tick_o;

   modport master (
      output en,
      output btn_raw,
      input  btn_db,
      input  btn_rise,
      input  btn_fall,
      input  tick_o
   );

   modport slave (
      input  en,
      input  btn_raw,
      output btn_db,
      output btn_rise,
      output btn_fall,
      output tick_o
   );
endinterface

// File: rtl/debounce_sync_ctrl.sv
// Multi-channel push-button debouncer: 2-flop synchronizers, shared sample-tick prescaler
// and one four-state qualification FSM per channel with registered level and edge outputs.
module debounce_sync_ctrl #(
   parameter int N_CH         = 4,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 10
) (
   input logic                 clk,
   input logic                 rst,
   debounce_sync_ctrl_if.slave bus
);
   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      ST_PEND_H = 2'd1,
      ST_HIGH   = 2'd2,
      ST_PEND_L = 2'd3
   } state_t;

   logic [N_CH-1:0] sync1_q, sync2_q;
   logic [PW-1:0]   pre_q, pre_d;
   logic            tick_q, tick_d;
   state_t          state_q [N_CH];
   state_t          state_d [N_CH];
   logic [CW-1:0]   cnt_q [N_CH];
   logic [CW-1:0]   cnt_d [N_CH];
   logic [N_CH-1:0] db_q, db_d;
   logic [N_CH-1:0] rise_q, rise_d;
   logic [N_CH-1:0] fall_q, fall_d;

   // Prescaler: free-runs while enabled, registered tick in the cycle after the last count.
   always_comb begin
      pre_d  = pre_q;
      tick_d = 1'b0;
      if (!bus.en) begin
         pre_d  = '0;
         tick_d = 1'b0;
      end else if (pre_q == PRE_LAST) begin
         pre_d  = '0;
         tick_d = 1'b1;
      end else begin
         pre_d  = pre_q + PRE_ONE;
         tick_d = 1'b0;
      end
   end

   // Per-channel qualification: a mismatch aborts before any tick in the same cycle is counted.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         db_d[i]    = db_q[i];
         rise_d[i]  = 1'b0;
         fall_d[i]  = 1'b0;
         case (state_q[i])
            ST_LOW: begin
               if (bus.en && sync2_q[i]) begin
                  state_d[i] = ST_PEND_H;
                  cnt_d[i]   = '0;
               end else begin
                  state_d[i] = ST_LOW;
               end
            end
            ST_PEND_H: begin
               if (!bus.en || !sync2_q[i]) begin
                  state_d[i] = ST_LOW;
                  cnt_d[i]   = '0;
               end else if (tick_q) begin
                  if (cnt_q[i] == CNT_LAST) begin
                     state_d[i] = ST_HIGH;
                     cnt_d[i]   = '0;
                     db_d[i]    = 1'b1;
                     rise_d[i]  = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i];
               end
            end
            ST_HIGH: begin
               if (bus.en && !sync2_q[i]) begin
                  state_d[i] = ST_PEND_L;
                  cnt_d[i]   = '0;
               end else begin
                  state_d[i] = ST_HIGH;
               end
            end
            ST_PEND_L: begin
               if (!bus.en || sync2_q[i]) begin
                  state_d[i] = ST_HIGH;
                  cnt_d[i]   = '0;
               end else if (tick_q) begin
                  if (cnt_q[i] == CNT_LAST) begin
                     state_d[i] = ST_LOW;
                     cnt_d[i]   = '0;
                     db_d[i]    = 1'b0;
                     fall_d[i]  = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i];
               end
            end
            default: begin
               state_d[i] = ST_LOW;
               cnt_d[i]   = '0;
               db_d[i]    = 1'b0;
            end
         endcase
      end
   end

   // All state, including the synchronizers, clears asynchronously on rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         pre_q   <= '0;
         tick_q  <= 1'b0;
         db_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= ST_LOW;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q <= bus.btn_raw;
         sync2_q <= sync1_q;
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign bus.btn_db   = db_q;
   assign bus.btn_rise = rise_q;
   assign bus.btn_fall = fall_q;
   assign bus.tick_o   = tick_q;
endmodule

// File: tb/tb_debounce_sync_ctrl.sv
// Bench for debounce_sync_ctrl: vector table, directed corner sequences and random traffic,
// all compared every cycle against a pending/tick-counting model of the debounce rules.
module tb_debounce_sync_ctrl;
   localparam int N_CH = 4;
   localparam int TD   = 4;
   localparam int ST   = 3;

   logic clk = 1'b0;
   logic rst;

   debounce_sync_ctrl_if #(.N_CH(N_CH)) bus ();

   debounce_sync_ctrl #(.N_CH(N_CH), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: accepted level, pending flag and ticks seen while pending, per channel.
   logic [N_CH-1:0] m_s1, m_s2, m_db, m_pend, m_rise, m_fall;
   logic            m_tick;
   int              m_run;
   int              m_cnt [N_CH];

   typedef struct {
      logic            en;
      logic [N_CH-1:0] raw;
      int              cycles;
      logic [N_CH-1:0] exp_db;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0; m_rise = '0; m_fall = '0;
      m_tick = 1'b0; m_run = 0;
      for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
   endtask

   task automatic model_step();
      logic new_tick;
      new_tick = bus.en && ((m_run % TD) == (TD - 1));
      m_run    = bus.en ? m_run + 1 : 0;
      m_rise   = '0;
      m_fall   = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (!bus.en) begin
            m_pend[c] = 1'b0;
            m_cnt[c]  = 0;
         end else if (m_pend[c]) begin
            if (m_s2[c] == m_db[c]) begin
               m_pend[c] = 1'b0;
            end else if (m_tick) begin
               m_cnt[c]++;
               if (m_cnt[c] == ST) begin
                  m_db[c]   = ~m_db[c];
                  m_rise[c] = m_db[c];
                  m_fall[c] = ~m_db[c];
                  m_pend[c] = 1'b0;
               end
            end
         end else if (m_s2[c] != m_db[c]) begin
            m_pend[c] = 1'b1;
            m_cnt[c]  = 0;
         end
      end
      m_s2   = m_s1;
      m_s1   = bus.btn_raw;
      m_tick = new_tick;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("model_db",   bus.btn_db,   m_db);
      chk("model_rise", bus.btn_rise, m_rise);
      chk("model_fall", bus.btn_fall, m_fall);
      chk("model_tick", bus.tick_o,   m_tick);
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   int              lat, found, quiet, pulses, rises, falls, tick_seen, first_tick, rise_at;
   logic            rise0;
   logic [N_CH-1:0] rise_val;
   int              rise_cnt [N_CH];

   initial begin
      tbl[0] = '{1'b1, 4'h0,  4, 4'h0};
      tbl[1] = '{1'b1, 4'h1, 16, 4'h1};
      tbl[2] = '{1'b1, 4'h3, 16, 4'h3};
      tbl[3] = '{1'b0, 4'h0, 20, 4'h3};
      tbl[4] = '{1'b1, 4'h0, 16, 4'h0};
      tbl[5] = '{1'b1, 4'hF,  2, 4'h0};
      tbl[6] = '{1'b1, 4'hF, 16, 4'hF};

      rst = 1'b1; bus.en = 1'b0; bus.btn_raw = '0;
      model_reset();
      #1;
      chk("reset_db",   bus.btn_db,   32'h0);
      chk("reset_rise", bus.btn_rise, 32'h0);
      chk("reset_fall", bus.btn_fall, 32'h0);
      chk("reset_tick", bus.tick_o,   32'h0);
      #20;
      @(negedge clk);
      rst = 1'b0;

      // Vector table
      for (int v = 0; v < 7; v++) begin
         bus.en = tbl[v].en;
         bus.btn_raw = tbl[v].raw;
         run(tbl[v].cycles);
         chk($sformatf("vec%0d_db", v), bus.btn_db, tbl[v].exp_db);
      end

      // Clean press on ch0, latency and pulse width
      bus.btn_raw = 4'h0;
      run(20);
      bus.btn_raw = 4'h1;
      found = 0; lat = 0; quiet = 1; rise0 = 1'b0;
      for (int k = 1; k <= 30 && found == 0; k++) begin
         cyc();
         if (bus.btn_rise[3:1] != 3'b000 || bus.btn_db[3:1] != 3'b000) quiet = 0;
         if (bus.btn_db[0]) begin
            found = 1; lat = k; rise0 = bus.btn_rise[0];
         end
      end
      checks++;
      if (lat < 12 || lat > 15) begin
         errors++;
         $display("FAIL press_latency got %0d expected 12..15", lat);
      end
      chk("press_rise_at_accept", rise0, 32'h1);
      cyc();
      chk("press_rise_width", bus.btn_rise[0], 32'h0);
      chk("press_others_quiet", quiet, 32'h1);

      // Bounce on ch1, then hold
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         if (k % 3 == 0) bus.btn_raw[1] = ~bus.btn_raw[1];
         cyc();
         if (bus.btn_rise[1] || bus.btn_fall[1]) pulses++;
      end
      chk("bounce_no_pulses", pulses, 32'h0);
      bus.btn_raw[1] = 1'b1;
      rises = 0; falls = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (bus.btn_rise[1]) rises++;
         if (bus.btn_fall[1]) falls++;
      end
      chk("bounce_rise_count", rises, 32'h1);
      chk("bounce_fall_count", falls, 32'h0);
      chk("bounce_db", bus.btn_db[1], 32'h1);

      // ch2 release glitch whose abort coincides with tick_o
      bus.btn_raw = 4'h7;
      run(20);
      chk("abort_setup_db", bus.btn_db, 32'h7);
      found = 0;
      for (int k = 0; k < 8 && found == 0; k++) begin
         cyc();
         if (bus.tick_o) found = 1;
      end
      chk("abort_tick_found", found, 32'h1);
      cyc();
      bus.btn_raw[2] = 1'b0;
      cyc();
      bus.btn_raw[2] = 1'b1;
      cyc();
      cyc();
      chk("abort_tick_coincide", bus.tick_o, 32'h1);
      falls = 0;
      for (int k = 0; k < 15; k++) begin
         cyc();
         if (bus.btn_fall[2]) falls++;
      end
      chk("abort_no_fall", falls, 32'h0);
      chk("abort_db", bus.btn_db[2], 32'h1);

      // Enable gating during PEND_H on ch3
      bus.btn_raw = 4'h0;
      run(20);
      bus.btn_raw[3] = 1'b1;
      run(5);
      bus.en = 1'b0;
      tick_seen = 0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (bus.tick_o) tick_seen++;
      end
      chk("gate_no_tick", tick_seen, 32'h0);
      chk("gate_db3", bus.btn_db[3], 32'h0);
      bus.en = 1'b1;
      first_tick = 0; rise_at = 0;
      for (int k = 1; k <= 20 && rise_at == 0; k++) begin
         cyc();
         if (bus.tick_o && first_tick == 0) first_tick = k;
         if (bus.btn_rise[3]) rise_at = k;
      end
      chk("gate_first_tick", first_tick, 32'd4);
      chk("gate_rise_at", rise_at, 32'd13);

      // Concurrent press on ch0 and ch2
      bus.btn_raw = 4'h0;
      run(20);
      bus.btn_raw = 4'h5;
      rise_val = '0;
      for (int k = 0; k < 30 && rise_val == 4'h0; k++) begin
         cyc();
         rise_val = bus.btn_rise;
      end
      chk("concurrent_rise", rise_val, 32'h5);
      chk("concurrent_quiet_db", bus.btn_db & 4'hA, 32'h0);

      // Mid-operation reset with all pins high
      bus.btn_raw = 4'hF;
      run(8);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("midrst_db",   bus.btn_db,   32'h0);
      chk("midrst_rise", bus.btn_rise, 32'h0);
      chk("midrst_fall", bus.btn_fall, 32'h0);
      chk("midrst_tick", bus.tick_o,   32'h0);
      @(posedge clk);
      #1;
      chk("midrst_hold_db", bus.btn_db, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < N_CH; c++) rise_cnt[c] = 0;
      for (int k = 0; k < 25; k++) begin
         cyc();
         for (int c = 0; c < N_CH; c++) if (bus.btn_rise[c]) rise_cnt[c]++;
      end
      for (int c = 0; c < N_CH; c++) chk($sformatf("postrst_rise_ch%0d", c), rise_cnt[c], 32'h1);
      chk("postrst_db", bus.btn_db, 32'hF);

      // Random traffic against the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 99) < 3) bus.en = ~bus.en;
         for (int c = 0; c < N_CH; c++)
            if ($urandom_range(0, 15) == 0) bus.btn_raw[c] = ~bus.btn_raw[c];
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
